// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, a single-entry
// output buffer toward the decoder, redirect/kill handling and ECALL halt.
//
// state | meaning
// IDLE  | first cycle after reset, no request issued
// REQ   | imem_req asserted at pc, waiting for imem_ack
// OUT   | instruction buffered, inst_valid asserted until inst_ready
// HALT  | ECALL retired, fetch stopped until a redirect
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_OUT  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic [31:0] kill_pc_q, kill_pc_d;
   logic [31:0] inst_data_q, inst_data_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        imem_req_q, imem_req_d;
   logic        inst_valid_q, inst_valid_d;
   logic        halted_q, halted_d;
   logic [31:0] redirect_tgt;

   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      kill_d        = kill_q;
      kill_pc_d     = kill_pc_q;
      inst_data_d   = inst_data_q;
      inst_pc_d     = inst_pc_q;
      fetch_count_d = fetch_count_q;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (redirect_valid) pc_d = redirect_tgt;
         end
         ST_REQ: begin
            if (imem_ack) begin
               // A redirect in the ack cycle beats any earlier latched target.
               if (redirect_valid) begin
                  pc_d   = redirect_tgt;
                  kill_d = 1'b0;
               end else if (kill_q) begin
                  pc_d   = kill_pc_q;
                  kill_d = 1'b0;
               end else begin
                  inst_data_d = imem_rdata;
                  inst_pc_d   = pc_q;
                  pc_d        = pc_q + 32'd4;
                  state_d     = ST_OUT;
               end
            end else if (redirect_valid) begin
               // The address must stay put until the outstanding read returns.
               kill_d    = 1'b1;
               kill_pc_d = redirect_tgt;
            end
         end
         ST_OUT: begin
            if (inst_ready) fetch_count_d = fetch_count_q + 32'd1;
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = ST_REQ;
            end else if (inst_ready) begin
               state_d = (inst_data_q[6:0] == OPC_SYSTEM) ? ST_HALT : ST_REQ;
            end
         end
         ST_HALT: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      imem_req_d   = (state_d == ST_REQ);
      inst_valid_d = (state_d == ST_OUT);
      halted_d     = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         kill_q        <= 1'b0;
         kill_pc_q     <= 32'd0;
         inst_data_q   <= 32'd0;
         inst_pc_q     <= 32'd0;
         fetch_count_q <= 32'd0;
         imem_req_q    <= 1'b0;
         inst_valid_q  <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         kill_q        <= kill_d;
         kill_pc_q     <= kill_pc_d;
         inst_data_q   <= inst_data_d;
         inst_pc_q     <= inst_pc_d;
         fetch_count_q <= fetch_count_d;
         imem_req_q    <= imem_req_d;
         inst_valid_q  <= inst_valid_d;
         halted_q      <= halted_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign inst_valid  = inst_valid_q;
   assign inst_data   = inst_data_q;
   assign inst_pc     = inst_pc_q;
   assign halted      = halted_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a flag-level fetch model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        halted;
   logic [31:0] fetch_count;

   logic        w_rst_n = 1'b0;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack = 1'b0;
   logic [31:0] w_rdata = 32'd0;
   logic        w_valid;
   logic [31:0] w_data;
   logic [31:0] w_pc;
   logic        w_halted;
   logic [31:0] w_count;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted), .fetch_count(fetch_count)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(w_rst_n),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
      .inst_valid(w_valid), .inst_ready(1'b1), .inst_data(w_data), .inst_pc(w_pc),
      .redirect_valid(1'b0), .redirect_pc(32'd0),
      .halted(w_halted), .fetch_count(w_count)
   );

   int n_vec = 0;
   int n_err = 0;
   bit done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   bit          mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = 32'd0;
   int          mem_lat = 1;
   bit          mem_started = 1'b0;
   bit          spurious_en = 1'b0;
   bit          rand_words = 1'b0;
   bit          ecall_en = 1'b0;
   logic [31:0] ecall_addr = 32'd0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (ecall_en && a == ecall_addr) return 32'h0000_0073;
      if (rand_words) begin
         w = $urandom;
         w[6:0] = ($urandom_range(0, 7) == 0) ? 7'h73 : 7'h13;
         return w;
      end
      return {a[24:0], 7'h13};
   endfunction

   // Advance to the next falling edge, run the memory, then drive decoder/redirect inputs.
   task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
      @(negedge clk);
      mem_started = 1'b0;
      imem_ack = 1'b0;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_ack = 1'b1;
            imem_rdata = mem_word(mem_addr);
            mem_busy = 1'b0;
         end
      end else if (imem_req) begin
         mem_busy = 1'b1;
         mem_addr = imem_addr;
         mem_cnt = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
         mem_started = 1'b1;
      end else if (spurious_en && $urandom_range(0, 3) == 0) begin
         imem_ack = 1'b1;
         imem_rdata = $urandom;
      end
      redirect_valid = rv;
      redirect_pc = rpc;
      inst_ready = rdy;
   endtask

   // ---------------- reference model ----------------
   // Flags: started (past the first post-reset edge), halt, have (buffered
   // instruction), kill (a redirect is waiting behind an outstanding read).
   bit          m_started, m_halt, m_have, m_kill;
   logic [31:0] m_pc, m_kpc, m_dat, m_ipc, m_cnt;

   task automatic m_reset();
      m_started = 0; m_halt = 0; m_have = 0; m_kill = 0;
      m_pc = 32'h0; m_kpc = 32'h0; m_dat = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
   endtask

   task automatic m_step(input logic rv, input logic [31:0] rpc, input logic ack,
                         input logic [31:0] rdata, input logic rdy);
      logic [31:0] tgt;
      tgt = {rpc[31:2], 2'b00};
      if (!m_started) begin
         m_started = 1;
         if (rv) m_pc = tgt;
      end else if (m_halt) begin
         if (rv) begin m_halt = 0; m_pc = tgt; end
      end else if (m_have) begin
         if (rdy) m_cnt = m_cnt + 1;
         if (rv) begin
            m_have = 0; m_pc = tgt;
         end else if (rdy) begin
            m_have = 0;
            if (m_dat[6:0] == 7'h73) m_halt = 1;
         end
      end else begin
         if (ack) begin
            if (rv) begin m_pc = tgt; m_kill = 0; end
            else if (m_kill) begin m_pc = m_kpc; m_kill = 0; end
            else begin m_have = 1; m_dat = rdata; m_ipc = m_pc; m_pc = m_pc + 4; end
         end else if (rv) begin
            m_kill = 1; m_kpc = tgt;
         end
      end
   endtask

   initial begin
      bit fetching;
      m_reset();
      while (!done) begin
         @(posedge clk);
         if (!rst_n) m_reset();
         else m_step(redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready);
         #1;
         fetching = m_started && !m_halt && !m_have;
         chk("model imem_req", {31'd0, imem_req}, {31'd0, fetching});
         chk("model inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
         chk("model halted", {31'd0, halted}, {31'd0, m_halt});
         chk("model fetch_count", fetch_count, m_cnt);
         if (fetching || !rst_n) chk("model imem_addr", imem_addr, m_pc);
         if (m_have || !rst_n) begin
            chk("model inst_data", inst_data, m_dat);
            chk("model inst_pc", inst_pc, m_ipc);
         end
      end
   end

   // ---------------- stimulus and directed checks ----------------
   initial begin
      logic [31:0] addrs [4];
      logic [31:0] pcs [4];
      logic [31:0] d0, p0, wa [2], wpc;
      int nreq, hs, nw;
      bit ok, seen;

      cyc(0, 32'd0, 0);
      cyc(0, 32'd0, 0);
      chk("reset imem_req", {31'd0, imem_req}, 32'd0);
      chk("reset inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("reset halted", {31'd0, halted}, 32'd0);
      chk("reset inst_data", inst_data, 32'd0);
      chk("reset inst_pc", inst_pc, 32'd0);
      chk("reset fetch_count", fetch_count, 32'd0);
      chk("reset imem_addr", imem_addr, 32'd0);
      rst_n = 1'b1;

      // Straight line, single-cycle memory, decoder always ready.
      for (int i = 0; i < 4; i++) begin addrs[i] = 32'hDEAD_BEEF; pcs[i] = 32'hDEAD_BEEF; end
      nreq = 0; hs = 0;
      for (int i = 0; i < 40 && hs < 3; i++) begin
         cyc(0, 32'd0, 1);
         if (mem_started && nreq < 4) begin addrs[nreq] = imem_addr; nreq++; end
         if (inst_valid) begin pcs[hs] = inst_pc; hs++; end
      end
      chk("line handshakes", hs, 3);
      chk("line addr0", addrs[0], 32'h0);
      chk("line addr1", addrs[1], 32'h4);
      chk("line addr2", addrs[2], 32'h8);
      chk("line pc0", pcs[0], 32'h0);
      chk("line pc1", pcs[1], 32'h4);
      chk("line pc2", pcs[2], 32'h8);
      cyc(0, 32'd0, 0);
      chk("line fetch_count", fetch_count, 32'd3);

      // Backpressure.
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc(0, 32'd0, 0);
         seen = inst_valid;
      end
      chk("bp valid reached", {31'd0, seen}, 32'd1);
      d0 = inst_data; p0 = inst_pc;
      chk("bp inst_pc", p0, 32'hC);
      chk("bp inst_data", d0, 32'h0000_0613);
      ok = 1;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 32'd0, 0);
         if (!inst_valid || inst_data !== d0 || inst_pc !== p0 || imem_req || fetch_count !== 32'd3) ok = 0;
      end
      chk("bp held stable", {31'd0, ok}, 32'd1);
      mem_lat = 3;
      cyc(0, 32'd0, 1);

      // Killed fetch: latency 3, redirect one cycle into the wait.
      cyc(0, 32'd0, 0);
      chk("bp fetch_count after", fetch_count, 32'd4);
      chk("kill addr start", imem_addr, 32'h10);
      cyc(1, 32'h100, 0);
      ok = !inst_valid;
      cyc(0, 32'd0, 0);
      chk("kill addr held", imem_addr, 32'h10);
      ok = ok && !inst_valid;
      cyc(0, 32'd0, 0);
      chk("kill addr at ack", imem_addr, 32'h10);
      ok = ok && !inst_valid && imem_ack;
      mem_lat = 1; ecall_en = 1; ecall_addr = 32'h100;
      cyc(0, 32'd0, 0);
      ok = ok && !inst_valid && imem_req;
      chk("kill no inst_valid", {31'd0, ok}, 32'd1);
      chk("kill next addr", imem_addr, 32'h100);

      // ECALL halts fetch, redirect restarts it.
      cyc(0, 32'd0, 0);
      cyc(0, 32'd0, 1);
      chk("ecall inst_data", inst_data, 32'h0000_0073);
      chk("ecall inst_pc", inst_pc, 32'h100);
      cyc(0, 32'd0, 0);
      cyc(0, 32'd0, 0);
      chk("ecall halted", {31'd0, halted}, 32'd1);
      chk("ecall imem_req", {31'd0, imem_req}, 32'd0);
      chk("ecall fetch_count", fetch_count, 32'd5);
      ecall_addr = 32'h40;
      cyc(1, 32'h40, 0);
      cyc(0, 32'd0, 0);
      chk("restart halted", {31'd0, halted}, 32'd0);
      chk("restart imem_addr", imem_addr, 32'h40);

      // Redirect together with a handshake of an ECALL word.
      cyc(0, 32'd0, 0);
      cyc(1, 32'h203, 1);
      chk("simul valid before", {31'd0, inst_valid}, 32'd1);
      mem_lat = 3;
      cyc(0, 32'd0, 0);
      chk("simul fetch_count", fetch_count, 32'd6);
      chk("simul imem_addr", imem_addr, 32'h200);
      chk("simul not halted", {31'd0, halted}, 32'd0);
      chk("simul imem_req", {31'd0, imem_req}, 32'd1);

      // Reset in the middle of a request, late ack in the first cycle after release.
      cyc(0, 32'd0, 0);
      rst_n = 1'b0; mem_busy = 0; imem_ack = 1'b0;
      #1;
      chk("midreset imem_req", {31'd0, imem_req}, 32'd0);
      cyc(0, 32'd0, 0);
      chk("midreset fetch_count", fetch_count, 32'd0);
      cyc(0, 32'd0, 0);
      rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
      cyc(0, 32'd0, 0);
      chk("late ack ignored", {31'd0, inst_valid}, 32'd0);
      chk("late ack addr", imem_addr, 32'h0);
      chk("late ack req", {31'd0, imem_req}, 32'd1);

      // Randomized traffic.
      ecall_en = 0; rand_words = 1; spurious_en = 1; mem_lat = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0; mem_busy = 0; imem_ack = 1'b0;
            cyc(0, 32'd0, 0);
            cyc(0, 32'd0, 0);
            rst_n = 1'b1;
         end
         cyc($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 1) == 1);
      end
      imem_ack = 1'b0; redirect_valid = 1'b0;

      // Wrap of pc from the top of the address space.
      @(negedge clk);
      w_rst_n = 1'b1;
      nw = 0; wpc = 32'hDEAD_BEEF; wa[0] = 32'hDEAD_BEEF; wa[1] = 32'hDEAD_BEEF;
      for (int i = 0; i < 20 && nw < 2; i++) begin
         @(negedge clk);
         if (w_valid && wpc === 32'hDEAD_BEEF) wpc = w_pc;
         if (w_ack) w_ack = 1'b0;
         else if (w_req) begin
            wa[nw] = w_addr; nw++;
            w_ack = 1'b1; w_rdata = 32'h0000_0013;
         end
      end
      chk("wrap first addr", wa[0], 32'hFFFF_FFFC);
      chk("wrap second addr", wa[1], 32'h0000_0000);
      chk("wrap inst_pc", wpc, 32'hFFFF_FFFC);

      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
